// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: serialises instruction-cache misses and data-port requests
// onto one AXI master, one single-beat transaction at a time.
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   inst_cache_*              instruction miss port (req/addr in, rdata/dok out)
//   data_*                    data port (req/wr/size/addr/wdata/wstrb in, rdata/dok out)
//   ar*/r*/aw*/w*/b*          AXI master channels, single beat, INCR, fixed ids
module cache_axi_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_dok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic [31:0] data_rdata,
    output logic        data_dok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;
    state_t      r_state, w_next;
    logic        r_own_d, r_aw_done, r_w_done;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr, r_wdata, r_irdata, r_drdata;
    logic        w_grant;
    assign w_grant = r_state == S_IDLE && (data_req || inst_cache_req);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = data_req ? (data_wr ? S_AW_W : S_AR) : inst_cache_req ? S_AR : S_IDLE;
            S_AR:   w_next = arready ? S_R : S_AR;
            S_R:    w_next = rvalid ? S_DONE : S_R;
            // both handshakes may finish in the same cycle or in either order
            S_AW_W: w_next = (r_aw_done || awready) && (r_w_done || wready) ? S_B : S_AW_W;
            S_B:    w_next = bvalid ? S_DONE : S_B;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_own_d   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_size    <= 2'd0;
            r_wstrb   <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_irdata  <= 32'd0;
            r_drdata  <= 32'd0;
        end else begin
            if (w_grant) begin
                r_own_d   <= data_req;
                r_addr    <= data_req ? data_addr : inst_cache_addr;
                r_size    <= data_req ? data_size : 2'd2;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (data_req) begin
                    r_wdata <= data_wdata;
                    r_wstrb <= data_wstrb;
                end
            end
            if (awvalid && awready) r_aw_done <= 1'b1;
            if (wvalid && wready)   r_w_done  <= 1'b1;
            if (rready && rvalid) begin
                if (r_own_d) r_drdata <= rdata;
                else         r_irdata <= rdata;
            end
        end
    end
    // instruction fetches are always word aligned; the full address is kept so
    // the data side can issue sub-word accesses from the same register
    assign araddr           = r_own_d ? r_addr : {r_addr[31:2], 2'b00};
    assign arsize           = {1'b0, r_size};
    assign arid             = {3'b000, r_own_d};
    assign arlen            = 4'd0;
    assign arburst          = 2'b01;
    assign arvalid          = r_state == S_AR;
    assign rready           = r_state == S_R;
    assign awid             = 4'd1;
    assign awaddr           = r_addr;
    assign awlen            = 4'd0;
    assign awsize           = {1'b0, r_size};
    assign awburst          = 2'b01;
    assign awvalid          = r_state == S_AW_W && !r_aw_done;
    assign wid              = 4'd1;
    assign wdata            = r_wdata;
    assign wstrb            = r_wstrb;
    assign wlast            = 1'b1;
    assign wvalid           = r_state == S_AW_W && !r_w_done;
    assign bready           = r_state == S_B;
    assign inst_cache_dok   = r_state == S_DONE && !r_own_d;
    assign data_dok         = r_state == S_DONE && r_own_d;
    assign inst_cache_rdata = r_irdata;
    assign data_rdata       = r_drdata;
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed and randomized transactions against a timeline model.
module tb_cache_axi_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_cache_req, data_req, data_wr;
    logic [31:0] inst_cache_addr, data_addr, data_wdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] inst_cache_rdata, data_rdata;
    logic        inst_cache_dok, data_dok;
    logic [3:0]  arid, arlen, awid, awlen, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] last_i = 32'd0;
    logic [31:0] last_d = 32'd0;

    always #5 clk = ~clk;

    cache_axi_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
        .inst_cache_rdata(inst_cache_rdata), .inst_cache_dok(inst_cache_dok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_rdata(data_rdata), .data_dok(data_dok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " arvalid"}, arvalid, 0);
        chk({tag, " rready"}, rready, 0);
        chk({tag, " awvalid"}, awvalid, 0);
        chk({tag, " wvalid"}, wvalid, 0);
        chk({tag, " bready"}, bready, 0);
        chk({tag, " inst_dok"}, inst_cache_dok, 0);
        chk({tag, " data_dok"}, data_dok, 0);
        chk({tag, " inst_rdata"}, inst_cache_rdata, last_i);
        chk({tag, " data_rdata"}, data_rdata, last_d);
    endtask

    // One transaction, entered in an IDLE cycle. Expected cycle numbers follow
    // directly from the latency rules: one cycle per handshake stage plus waits.
    task automatic txn(input bit d, input bit wr_in, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input logic [31:0] rd,
                       input int wa, input int wb, input int wc, input bit keep);
        bit          w;
        int          t_r, t_b, t;
        logic [31:0] ea;
        logic [2:0]  esz;
        w   = d && wr_in;
        ea  = d ? a : (a & 32'hFFFF_FFFC);
        esz = d ? {1'b0, sz} : 3'd2;
        t_r = wa + 2;
        t_b = (wa > wb ? wa : wb) + 2;
        t   = w ? t_b + wc + 1 : t_r + wb + 1;
        if (d) begin
            data_req = 1; data_wr = w; data_size = sz; data_addr = a; data_wdata = wd; data_wstrb = st;
        end else begin
            inst_cache_req = 1; inst_cache_addr = a;
        end
        for (int c = 1; c <= t; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                if (d) begin data_addr = $urandom; data_wdata = $urandom; data_wstrb = 4'($urandom); end
                else inst_cache_addr = $urandom;
            end
            arready = !w && c == wa + 1;
            rvalid  = !w && c == t - 1;
            rdata   = (!w && c == t - 1) ? rd : $urandom;
            awready = w && c == wa + 1;
            wready  = w && c == wb + 1;
            bvalid  = w && c == t - 1;
            chk("arvalid", arvalid, !w && c <= wa + 1);
            chk("rready", rready, !w && c >= t_r && c < t);
            chk("awvalid", awvalid, w && c <= wa + 1);
            chk("wvalid", wvalid, w && c <= wb + 1);
            chk("bready", bready, w && c >= t_b && c < t);
            chk("inst_dok", inst_cache_dok, !d && c == t);
            chk("data_dok", data_dok, d && c == t);
            if (!w && c <= wa + 1) begin
                chk("araddr", araddr, ea);
                chk("arid", arid, d);
                chk("arsize", arsize, esz);
            end
            if (w && c <= wa + 1) begin
                chk("awaddr", awaddr, a);
                chk("awsize", awsize, esz);
            end
            if (w && c <= wb + 1) begin
                chk("wdata", wdata, wd);
                chk("wstrb", wstrb, st);
            end
            if (c == t) begin
                if (!w && d) last_d = rd;
                if (!w && !d) last_i = rd;
                chk("inst_rdata", inst_cache_rdata, last_i);
                chk("data_rdata", data_rdata, last_d);
                if (!keep) begin
                    if (d) data_req = 0;
                    else inst_cache_req = 0;
                end
            end
        end
        @(posedge clk); #1;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        chk_idle("post");
    endtask

    initial begin
        resetn = 0;
        inst_cache_req = 0; inst_cache_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
        arready = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset araddr", araddr, 0);
        chk("reset awaddr", awaddr, 0);
        chk("reset wdata", wdata, 0);
        chk("arlen", arlen, 0);
        chk("awlen", awlen, 0);
        chk("arburst", arburst, 1);
        chk("awburst", awburst, 1);
        chk("wlast", wlast, 1);
        chk("awid", awid, 1);
        chk("wid", wid, 1);
        resetn = 1;
        // zero-wait instruction read
        txn(0, 0, 2, 32'hBFC0_0000, 0, 0, 32'h2408_0001, 0, 0, 0, 0);
        // simultaneous requests: data wins, instruction follows
        inst_cache_req = 1; inst_cache_addr = 32'h1000;
        txn(1, 0, 2, 32'h2000, 0, 0, 32'hCAFE_0001, 0, 0, 0, 0);
        txn(0, 0, 2, 32'h1000, 0, 0, 32'hCAFE_0002, 0, 0, 0, 0);
        // write with awready delayed two cycles, wready immediate
        txn(1, 1, 2, 32'h3000, 32'hDEAD_BEEF, 4'hF, 0, 2, 0, 0, 0);
        // slow read data
        txn(0, 0, 2, 32'h0000_4004, 0, 0, 32'h1357_9BDF, 0, 5, 0, 0);
        // reset while waiting in R
        inst_cache_req = 1; inst_cache_addr = 32'h5000;
        @(posedge clk); #1;
        arready = 1;
        @(posedge clk); #1;
        arready = 0;
        chk("pre-reset rready", rready, 1);
        resetn = 0;
        #1;
        chk("async rready", rready, 0);
        chk("async arvalid", arvalid, 0);
        chk("async inst_dok", inst_cache_dok, 0);
        chk("async data_dok", data_dok, 0);
        inst_cache_req = 0;
        last_i = 0; last_d = 0;
        @(posedge clk); #1;
        resetn = 1;
        chk_idle("after reset");
        txn(0, 0, 2, 32'h6000, 0, 0, 32'h600D_600D, 1, 1, 0, 0);
        // back-to-back instruction misses with req held across dok
        txn(0, 0, 2, 32'h0, 0, 0, 32'hAAAA_0000, 0, 0, 0, 1);
        txn(0, 0, 2, 32'h4, 0, 0, 32'hAAAA_0004, 0, 0, 0, 0);
        // randomized mix
        for (int i = 0; i < 30; i++) begin
            bit d;
            d = 1'($urandom);
            txn(d, 1'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom, 4'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
